// File: rtl/ppu_sprite_eval_param.sv
// Per-scanline sprite evaluator: scans OAM once per line, caches intersecting sprites,
// and presents up to TILE_OUT overlapping sprites per tile column every cycle.
module ppu_sprite_eval_param #(
  parameter int unsigned MAX_LINE_SPRITES = 8,
  parameter int unsigned TILE_OUT         = 2,
  parameter int unsigned OAM_ENTRIES      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  tall_mode,
  input  logic [7:0]            cpu_sprite_addr,
  input  logic [8:0]            curr_row,
  input  logic [8:0]            curr_col,
  output logic [7:0]            spram_addr,
  input  logic [7:0]            spram_data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  sprite_overflow,
  output logic [4:0]            hit_count,
  output logic [TILE_OUT-1:0]   out_valid,
  output logic [8*TILE_OUT-1:0] out_tile_num,
  output logic [8*TILE_OUT-1:0] out_row,
  output logic [8*TILE_OUT-1:0] out_col,
  output logic [8*TILE_OUT-1:0] out_attr,
  output logic [TILE_OUT-1:0]   out_is_0,
  output logic [2:0]            dbg_state
);

  // Handshake: start is a one-cycle pulse honoured only in IDLE; busy is high from the
  // cycle after start through the DONE cycle, and done pulses high in that DONE cycle.
  typedef enum logic [2:0] {IDLE = 3'd0, WAIT = 3'd1, CHECK = 3'd2, LOAD = 3'd3, DONE = 3'd4} state_t;

  state_t      state_q;
  logic [7:0]  base_q, addr_q;
  logic        tall_q, busy_q, done_q, overflow_q;
  logic [6:0]  entry_q;
  logic [1:0]  ld_cnt_q;
  logic [4:0]  hit_count_q;

  logic [7:0]  c_y_q    [MAX_LINE_SPRITES];
  logic [7:0]  c_tile_q [MAX_LINE_SPRITES];
  logic [7:0]  c_attr_q [MAX_LINE_SPRITES];
  logic [7:0]  c_x_q    [MAX_LINE_SPRITES];
  logic        c_is0_q  [MAX_LINE_SPRITES];
  logic        c_vld_q  [MAX_LINE_SPRITES];

  logic [TILE_OUT-1:0]   out_valid_q, out_valid_d, out_is0_q, out_is0_d;
  logic [8*TILE_OUT-1:0] out_tile_q, out_tile_d, out_row_q, out_row_d;
  logic [8*TILE_OUT-1:0] out_col_q, out_col_d, out_attr_q, out_attr_d;

  logic [9:0]  row_diff;
  logic        is_hit, cache_full, last_entry;
  logic [7:0]  next_y_addr;

  // 10-bit difference: a Y below curr_row wraps to a large value and fails the height test.
  assign row_diff    = {1'b0, curr_row} - {2'b00, spram_data_in};
  assign is_hit      = (spram_data_in < 8'hEF) && (row_diff < (tall_q ? 10'd16 : 10'd8));
  assign cache_full  = (hit_count_q == 5'(MAX_LINE_SPRITES));
  assign last_entry  = ((entry_q + 7'd1) == 7'(OAM_ENTRIES));
  assign next_y_addr = base_q + {entry_q[5:0] + 6'd1, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      tall_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      entry_q     <= '0;
      ld_cnt_q    <= '0;
      hit_count_q <= '0;
      for (int s = 0; s < MAX_LINE_SPRITES; s++) begin
        c_y_q[s] <= '0; c_tile_q[s] <= '0; c_attr_q[s] <= '0;
        c_x_q[s] <= '0; c_is0_q[s]  <= 1'b0; c_vld_q[s] <= 1'b0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q      <= cpu_sprite_addr;
            addr_q      <= cpu_sprite_addr;
            tall_q      <= tall_mode;
            entry_q     <= '0;
            hit_count_q <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b1;
            for (int s = 0; s < MAX_LINE_SPRITES; s++) c_vld_q[s] <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          // Pre-issue the tile address so a hit can start capturing in its first LOAD cycle.
          addr_q  <= addr_q + 8'd1;
          state_q <= CHECK;
        end
        CHECK: begin
          if (is_hit && cache_full) begin
            overflow_q <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else if (is_hit) begin
            for (int s = 0; s < MAX_LINE_SPRITES; s++) begin
              if (5'(s) == hit_count_q) begin
                c_y_q[s]   <= spram_data_in;
                c_is0_q[s] <= (entry_q == 7'd0);
              end
            end
            addr_q   <= addr_q + 8'd1;
            ld_cnt_q <= '0;
            state_q  <= LOAD;
          end else begin
            entry_q <= entry_q + 7'd1;
            if (last_entry) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              addr_q  <= next_y_addr;
              state_q <= WAIT;
            end
          end
        end
        LOAD: begin
          ld_cnt_q <= ld_cnt_q + 2'd1;
          for (int s = 0; s < MAX_LINE_SPRITES; s++) begin
            if (5'(s) == hit_count_q) begin
              case (ld_cnt_q)
                2'd0:    c_tile_q[s] <= spram_data_in;
                2'd1:    c_attr_q[s] <= spram_data_in;
                default: begin
                  c_x_q[s]   <= spram_data_in;
                  c_vld_q[s] <= 1'b1;
                end
              endcase
            end
          end
          if (ld_cnt_q == 2'd0) addr_q <= addr_q + 8'd1;
          if (ld_cnt_q == 2'd2) begin
            hit_count_q <= hit_count_q + 5'd1;
            entry_q     <= entry_q + 7'd1;
            if (last_entry) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              addr_q  <= next_y_addr;
              state_q <= WAIT;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Priority fill: the n-th overlapping slot in ascending order lands in channel n.
  always_comb begin
    logic signed [10:0] col_s, x_s;
    int n;
    out_valid_d = '0; out_is0_d  = '0; out_tile_d = '0;
    out_row_d   = '0; out_col_d  = '0; out_attr_d = '0;
    col_s = {{2{curr_col[8]}}, curr_col};
    x_s   = '0;
    n     = 0;
    for (int s = 0; s < MAX_LINE_SPRITES; s++) begin
      x_s = {3'b000, c_x_q[s]};
      if (c_vld_q[s] && (x_s + 11'sd8 > col_s) && (col_s + 11'sd8 > x_s)) begin
        for (int k = 0; k < TILE_OUT; k++) begin
          if (k == n) begin
            out_valid_d[k]       = 1'b1;
            out_is0_d[k]         = c_is0_q[s];
            out_tile_d[8*k +: 8] = c_tile_q[s];
            out_row_d[8*k +: 8]  = c_y_q[s];
            out_col_d[8*k +: 8]  = c_x_q[s];
            out_attr_d[8*k +: 8] = c_attr_q[s];
          end
        end
        n = n + 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= '0; out_is0_q <= '0; out_tile_q <= '0;
      out_row_q   <= '0; out_col_q <= '0; out_attr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d; out_is0_q <= out_is0_d; out_tile_q <= out_tile_d;
      out_row_q   <= out_row_d;   out_col_q <= out_col_d; out_attr_q <= out_attr_d;
    end
  end

  assign spram_addr      = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign sprite_overflow = overflow_q;
  assign hit_count       = hit_count_q;
  assign out_valid       = out_valid_q;
  assign out_tile_num    = out_tile_q;
  assign out_row         = out_row_q;
  assign out_col         = out_col_q;
  assign out_attr        = out_attr_q;
  assign out_is_0        = out_is0_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_ppu_sprite_eval_param.sv
// Directed bench for ppu_sprite_eval_param: OAM model with one-cycle read latency,
// hand-computed expectations for scan timing, caching, overflow and tile selection.
module tb_ppu_sprite_eval_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        tall_mode = 1'b0;
  logic [7:0]  cpu_sprite_addr = '0;
  logic [8:0]  curr_row = '0;
  logic [8:0]  curr_col = '0;
  logic [7:0]  spram_addr;
  logic [7:0]  spram_data_in = '0;
  logic        busy, done, sprite_overflow;
  logic [4:0]  hit_count;
  logic [1:0]  out_valid, out_is_0;
  logic [15:0] out_tile_num, out_row, out_col, out_attr;
  logic [2:0]  dbg_state;

  logic [7:0]  mem [256];
  logic [7:0]  addr_log [$];
  int total = 0;
  int bad   = 0;
  int busy_cnt, done_cnt;

  ppu_sprite_eval_param #(.MAX_LINE_SPRITES(8), .TILE_OUT(2), .OAM_ENTRIES(64)) dut (
    .clk(clk), .rst(rst), .start(start), .tall_mode(tall_mode),
    .cpu_sprite_addr(cpu_sprite_addr), .curr_row(curr_row), .curr_col(curr_col),
    .spram_addr(spram_addr), .spram_data_in(spram_data_in),
    .busy(busy), .done(done), .sprite_overflow(sprite_overflow), .hit_count(hit_count),
    .out_valid(out_valid), .out_tile_num(out_tile_num), .out_row(out_row),
    .out_col(out_col), .out_attr(out_attr), .out_is_0(out_is_0), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) spram_data_in <= mem[spram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_ff();
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
  endtask

  task automatic set_entry(input logic [7:0] base, input int e, input logic [7:0] y,
                           input logic [7:0] tile, input logic [7:0] attr, input logic [7:0] x);
    logic [7:0] a;
    a = base + 8'(4 * e);
    mem[a] = y;
    mem[a + 8'd1] = tile;
    mem[a + 8'd2] = attr;
    mem[a + 8'd3] = x;
  endtask

  // driver: pulse start, count busy/done cycles, log distinct OAM addresses
  task automatic run_scan(output int b_cnt, output int d_cnt);
    int cyc;
    b_cnt = 0;
    d_cnt = 0;
    addr_log.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 2000) begin
      if (busy) b_cnt++;
      if (done) d_cnt++;
      if (addr_log.size() == 0 || addr_log[$] != spram_addr) addr_log.push_back(spram_addr);
      if (done) break;
      @(negedge clk);
      cyc++;
    end
    check("scan_in_time", 32'(cyc < 2000), 32'd1);
    @(negedge clk);
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    fill_ff();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(sprite_overflow), 32'd0);
    check("rst_hits", 32'(hit_count), 32'd0);
    check("rst_addr", 32'(spram_addr), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;

    // all entries off-screen: 64 misses of 2 cycles plus DONE
    curr_row = 9'd12;
    run_scan(busy_cnt, done_cnt);
    check("empty_busy", busy_cnt, 32'd129);
    check("empty_done", done_cnt, 32'd1);
    check("empty_hits", 32'(hit_count), 32'd0);
    check("empty_ovf", 32'(sprite_overflow), 32'd0);
    check("empty_valid", 32'(out_valid), 32'd0);

    // single hit in entry 0
    set_entry(8'h00, 0, 8'd10, 8'h33, 8'h01, 8'd20);
    curr_col = 9'd16;
    run_scan(busy_cnt, done_cnt);
    check("one_busy", busy_cnt, 32'd132);
    check("one_hits", 32'(hit_count), 32'd1);
    check("one_valid", 32'(out_valid), 32'h1);
    check("one_tile", 32'(out_tile_num), 32'h0033);
    check("one_col", 32'(out_col), 32'h0014);
    check("one_row", 32'(out_row), 32'h000A);
    check("one_attr", 32'(out_attr), 32'h0001);
    check("one_is0", 32'(out_is_0), 32'h1);
    curr_col = 9'h1F0;
    @(negedge clk);
    check("one_far_left", 32'(out_valid), 32'h0);

    // ten hits on the same line, eight cache slots
    fill_ff();
    for (int e = 0; e < 10; e++) set_entry(8'h00, e, 8'd40, 8'(e), 8'h00, 8'(8 * e));
    curr_row = 9'd45;
    curr_col = 9'd4;
    run_scan(busy_cnt, done_cnt);
    check("ovf_busy", busy_cnt, 32'd43);
    check("ovf_hits", 32'(hit_count), 32'd8);
    check("ovf_flag", 32'(sprite_overflow), 32'd1);
    check("ovf_valid", 32'(out_valid), 32'h3);
    check("ovf_tile", 32'(out_tile_num), 32'h0100);
    check("ovf_is0", 32'(out_is_0), 32'h1);

    // 16-row vs 8-row height
    fill_ff();
    set_entry(8'h00, 0, 8'd100, 8'h11, 8'h00, 8'd50);
    curr_row = 9'd113;
    tall_mode = 1'b1;
    run_scan(busy_cnt, done_cnt);
    check("tall_hit", 32'(hit_count), 32'd1);
    tall_mode = 1'b0;
    run_scan(busy_cnt, done_cnt);
    check("short_miss", 32'(hit_count), 32'd0);
    check("ovf_cleared", 32'(sprite_overflow), 32'd0);

    // Y = 0xEF is never on screen
    fill_ff();
    set_entry(8'h00, 0, 8'hEF, 8'h11, 8'h00, 8'd50);
    curr_row = 9'h0F0;
    run_scan(busy_cnt, done_cnt);
    check("y_ef_miss", 32'(hit_count), 32'd0);

    // three sprites at X=0,2,4 with a negative tile column
    fill_ff();
    set_entry(8'h00, 0, 8'd40, 8'hA0, 8'h00, 8'd0);
    set_entry(8'h00, 1, 8'd40, 8'hA1, 8'h00, 8'd2);
    set_entry(8'h00, 2, 8'd40, 8'hA2, 8'h00, 8'd4);
    curr_row = 9'd40;
    curr_col = 9'h1FC;
    run_scan(busy_cnt, done_cnt);
    check("neg_hits", 32'(hit_count), 32'd3);
    check("neg_valid", 32'(out_valid), 32'h3);
    check("neg_tile", 32'(out_tile_num), 32'hA1A0);
    check("neg_col", 32'(out_col), 32'h0200);
    check("neg_is0", 32'(out_is_0), 32'h1);
    curr_col = 9'd9;
    @(negedge clk);
    check("col9_tile", 32'(out_tile_num), 32'hA2A1);
    check("col9_col", 32'(out_col), 32'h0402);
    check("col9_is0", 32'(out_is_0), 32'h0);

    // base address wraps past 0xFF
    fill_ff();
    set_entry(8'hFC, 0, 8'd5, 8'h77, 8'h02, 8'h10);
    set_entry(8'hFC, 1, 8'd5, 8'h88, 8'h03, 8'h14);
    cpu_sprite_addr = 8'hFC;
    curr_row = 9'd5;
    curr_col = 9'h010;
    run_scan(busy_cnt, done_cnt);
    check("wrap_hits", 32'(hit_count), 32'd2);
    check("wrap_log_len", 32'(addr_log.size() >= 5), 32'd1);
    if (addr_log.size() >= 5) begin
      check("wrap_a0", 32'(addr_log[0]), 32'hFC);
      check("wrap_a3", 32'(addr_log[3]), 32'hFF);
      check("wrap_a4", 32'(addr_log[4]), 32'h00);
    end
    check("wrap_tile", 32'(out_tile_num), 32'h8877);
    check("wrap_attr", 32'(out_attr), 32'h0302);
    check("wrap_is0", 32'(out_is_0), 32'h1);

    // reset mid-scan drops everything
    fill_ff();
    for (int e = 0; e < 10; e++) set_entry(8'h00, e, 8'd40, 8'(e), 8'h00, 8'(8 * e));
    cpu_sprite_addr = 8'h00;
    curr_row = 9'd45;
    curr_col = 9'd4;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_hits_nonzero", 32'(hit_count != 5'd0), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_hits", 32'(hit_count), 32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppu_sprite_eval_param.md
Name: ppu_sprite_eval_param

Overview:
Parametrised per-scanline sprite evaluator for the PPU. It scans sprite RAM (OAM) once per line, caches up to MAX_LINE_SPRITES sprites that intersect curr_row, and flags overflow. Every cycle it presents up to TILE_OUT cached sprites that overlap the current 8-pixel tile column to the sprite pixel pipeline. It supports 8x8 and 8x16 sprite heights and a configurable OAM scan length, and it reports sprite-0 identity and hit count.

Parameters:
MAX_LINE_SPRITES, 8, sprite cache depth (1..16)
TILE_OUT, 2, number of sprite output channels per tile (1..MAX_LINE_SPRITES)
OAM_ENTRIES, 64, entries scanned per evaluation (1..64)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a line evaluation
tall_mode  in  1  0 = 8-row sprites, 1 = 16-row sprites; sampled on start
cpu_sprite_addr  in  8  OAM byte address of entry 0; sampled on start
curr_row  in  9  scanline under evaluation; held stable while busy
curr_col  in  9  two's-complement tile column start; may be negative
spram_addr  out  8  OAM read address; data returns one cycle later
spram_data_in  in  8  OAM read data
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the scan ends
sprite_overflow  out  1  more than MAX_LINE_SPRITES hits on the line
hit_count  out  5  sprites cached (0..MAX_LINE_SPRITES)
out_valid  out  TILE_OUT  channel k holds a sprite
out_tile_num  out  8*TILE_OUT  tile byte; channel k at [8k+:8]
out_row  out  8*TILE_OUT  Y byte
out_col  out  8*TILE_OUT  X byte
out_attr  out  8*TILE_OUT  attribute byte
out_is_0  out  TILE_OUT  channel holds OAM entry 0

Behaviour:
- Reset: state IDLE; spram_addr=0; busy=0; done=0; sprite_overflow=0; hit_count=0; all cache rows invalid; all out_* = 0.
- spram_addr is registered. The byte at address A, presented in cycle N, is sampled in cycle N+1.
- Addressing: entry e occupies bytes cpu_sprite_addr + 4e + {0:Y, 1:tile, 2:attr, 3:X}, modulo 256; addresses wrap at 256.
- States:
  - IDLE: on start, latch the base address and tall_mode, invalidate the cache, clear overflow, hit_count and entry counter; present the Y address of entry 0; go to WAIT.
  - WAIT (1 cycle): go to CHECK.
  - CHECK: evaluate Y from spram_data_in.
    - H = tall_mode ? 16 : 8. Hit iff Y < 0xEF and 0 <= curr_row - Y < H, computed in 10-bit unsigned arithmetic so there is no overflow.
    - Miss: advance the entry; present the next Y address; go to WAIT. A miss costs 2 cycles.
    - Hit with the cache full: set sprite_overflow and go to DONE.
    - Hit with the cache not full: store Y in slot hit_count; set is_0 when entry==0; present the tile address; go to LOAD.
  - LOAD: 3 cycles, capturing tile, then attr, then X, each from the prior cycle's address. On the X capture, increment hit_count, advance the entry, present the next Y address, and go to WAIT. A hit costs 5 cycles.
  - After the last entry (entry == OAM_ENTRIES) instead of WAIT: go to DONE.
  - DONE (1 cycle): pulse done; go to IDLE.
- start while busy is ignored.
- Asynchronous reset during a scan aborts immediately to reset values; no partial cache survives.
- Output selection runs every cycle, independent of the FSM, and reads the cache.
  - Slot s overlaps iff valid and (X+8 > c) and (c+8 > X), evaluated as 11-bit signed with c = sign-extended curr_col and X zero-extended.
  - Channel k gets the k-th overlapping slot in ascending slot order; lowest slot has highest priority.
  - Unused channels: out_valid=0 and all fields 0.
  - Outputs are registered, one cycle latency from a curr_col change.
- Cache contents remain valid after done until the next start.
- sprite_overflow and hit_count hold until the next start or reset.

Test Plan:
- All Y=0xFF, OAM_ENTRIES=64, start -> busy for 129 cycles, then done pulse; hit_count=0; out_valid=0; overflow=0.
- Entry 0 Y=10, X=20, tile=0x33, attr=0x01; curr_row=12, curr_col=16 -> hit_count=1; channel 0: valid=1, tile 0x33, col 20, is_0=1.
- Ten entries with Y=40, curr_row=45, MAX_LINE_SPRITES=8 -> hit_count=8; overflow=1; done asserted after the 9th hit is detected.
- tall_mode=1, Y=100, curr_row=113 -> hit; tall_mode=0 with the same values -> miss.
- Three cached sprites at X=0, 2, 4; curr_col=0x1FC (-4); TILE_OUT=2 -> channels hold the sprites at X=0 and X=2 (slots 0 and 1); the X=4 sprite is dropped.
- cpu_sprite_addr=0xFC, entry 0 Y=5, curr_row=5 -> reads 0xFC..0xFF, then entry 1 is read at 0x00; is_0 is set for the 0xFC entry only.
